// File: rtl/dram_dma_sched.sv
// rtl/dram_dma_sched.sv - round-robin scheduler sharing the DRAM arbiter DMA port among DMA requesters
module dram_dma_sched #(
    parameter int CHANNELS = 4,
    parameter int BURST    = 8,
    parameter int TAGDEPTH = 4
) (
    input  logic                   fclk,
    input  logic                   rst_n,
    input  logic [CHANNELS-1:0]    ch_req,
    input  logic [CHANNELS-1:0]    ch_rnw,
    input  logic [21*CHANNELS-1:0] ch_addr,
    input  logic [16*CHANNELS-1:0] ch_wrdata,
    input  logic [2*CHANNELS-1:0]  ch_bsel,
    output logic [CHANNELS-1:0]    ch_next,
    output logic [CHANNELS-1:0]    ch_strobe,
    output logic [15:0]            ch_rddata,
    output logic                   dma_req,
    output logic                   dma_rnw,
    output logic [20:0]            dma_addr,
    output logic [15:0]            dma_wrdata,
    output logic [1:0]             dma_bsel,
    input  logic                   dma_next,
    input  logic                   dma_strobe,
    input  logic [15:0]            dma_rddata,
    output logic                   busy,
    output logic                   err
);
    localparam int PW = $clog2(TAGDEPTH);

    typedef enum logic {IDLE, OWN} state_t;

    state_t        state_q, state_d;
    logic [1:0]    grant_q, grant_d;
    logic [1:0]    last_q, last_d;
    logic [4:0]    bcnt_q, bcnt_d;
    logic [1:0]    tag_q [TAGDEPTH];
    logic [1:0]    tag_d [TAGDEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW:0]   cnt_q, cnt_d;
    logic          err_q, err_d;

    logic       sel_req, sel_rnw;
    logic       fifo_full, fifo_empty;
    logic       accept, push, pop;
    logic [1:0] pick;
    logic       found;
    logic [1:0] head_tag;

    always_comb begin
        sel_req    = 1'b0;
        sel_rnw    = 1'b0;
        dma_rnw    = 1'b0;
        dma_addr   = '0;
        dma_wrdata = '0;
        dma_bsel   = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (grant_q == 2'(i)) begin
                sel_req    = ch_req[i];
                sel_rnw    = ch_rnw[i];
                dma_rnw    = ch_rnw[i];
                dma_addr   = ch_addr[21*i +: 21];
                dma_wrdata = ch_wrdata[16*i +: 16];
                dma_bsel   = ch_bsel[2*i +: 2];
            end
        end
    end

    assign fifo_full  = (cnt_q == (PW+1)'(TAGDEPTH));
    assign fifo_empty = (cnt_q == '0);
    assign head_tag   = tag_q[rd_ptr_q];

    // Only reads need a tag slot, so a full FIFO stalls reads but never writes.
    assign dma_req = (state_q == OWN) && sel_req && !(sel_rnw && fifo_full);
    assign accept  = dma_req && dma_next;
    assign push    = accept && sel_rnw;
    assign pop     = dma_strobe && !fifo_empty;

    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            ch_next[i]   = accept && (grant_q == 2'(i));
            ch_strobe[i] = pop && (head_tag == 2'(i));
        end
    end

    assign ch_rddata = dma_rddata;
    assign busy      = (state_q == OWN) || !fifo_empty;
    assign err       = err_q;

    // Scan downward so the nearest channel after last wins the final assignment.
    always_comb begin
        int idx;
        pick  = last_q;
        found = 1'b0;
        idx   = 0;
        for (int k = CHANNELS; k >= 1; k--) begin
            idx = (int'(last_q) + k) % CHANNELS;
            if (ch_req[idx]) begin
                found = 1'b1;
                pick  = 2'(idx);
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        last_d   = last_q;
        bcnt_d   = bcnt_q;
        tag_d    = tag_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        err_d    = err_q;

        case (state_q)
            IDLE: begin
                if (found) begin
                    state_d = OWN;
                    grant_d = pick;
                    bcnt_d  = '0;
                end
            end
            OWN: begin
                if (accept) begin
                    bcnt_d = bcnt_q + 5'd1;
                    if (bcnt_q + 5'd1 == 5'(BURST)) begin
                        state_d = IDLE;
                        last_d  = grant_q;
                    end
                end else if (!sel_req) begin
                    state_d = IDLE;
                    last_d  = grant_q;
                end
            end
            default: state_d = IDLE;
        endcase

        if (push) begin
            tag_d[wr_ptr_q] = grant_q;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + (PW+1)'(1);
            2'b01:   cnt_d = cnt_q - (PW+1)'(1);
            default: cnt_d = cnt_q;
        endcase

        if (dma_strobe && fifo_empty) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge fclk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            last_q   <= 2'(CHANNELS-1);
            bcnt_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            err_q    <= 1'b0;
            for (int i = 0; i < TAGDEPTH; i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            last_q   <= last_d;
            bcnt_q   <= bcnt_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
            tag_q    <= tag_d;
        end
    end
endmodule

// File: tb/tb_dram_dma_sched.sv
// tb/tb_dram_dma_sched.sv - self-checking bench for dram_dma_sched against a queue-based model
module tb_dram_dma_sched;
    localparam int C  = 4;
    localparam int B  = 8;
    localparam int TD = 4;

    logic         fclk = 1'b0;
    logic         rst_n;
    logic [3:0]   ch_req, ch_rnw;
    logic [83:0]  ch_addr;
    logic [63:0]  ch_wrdata;
    logic [7:0]   ch_bsel;
    logic [3:0]   ch_next, ch_strobe;
    logic [15:0]  ch_rddata;
    logic         dma_req, dma_rnw;
    logic [20:0]  dma_addr;
    logic [15:0]  dma_wrdata;
    logic [1:0]   dma_bsel;
    logic         dma_next, dma_strobe;
    logic [15:0]  dma_rddata;
    logic         busy, err;

    always #5 fclk = ~fclk;

    dram_dma_sched #(.CHANNELS(C), .BURST(B), .TAGDEPTH(TD)) dut (
        .fclk(fclk), .rst_n(rst_n),
        .ch_req(ch_req), .ch_rnw(ch_rnw), .ch_addr(ch_addr),
        .ch_wrdata(ch_wrdata), .ch_bsel(ch_bsel),
        .ch_next(ch_next), .ch_strobe(ch_strobe), .ch_rddata(ch_rddata),
        .dma_req(dma_req), .dma_rnw(dma_rnw), .dma_addr(dma_addr),
        .dma_wrdata(dma_wrdata), .dma_bsel(dma_bsel),
        .dma_next(dma_next), .dma_strobe(dma_strobe), .dma_rddata(dma_rddata),
        .busy(busy), .err(err)
    );

    int n_pass  = 0;
    int n_total = 0;

    // Model: who owns the port, rotation pointer, burst count and the queue of read tags.
    bit   m_valid = 0;
    bit   m_own;
    int   m_grant, m_last, m_bcnt;
    int   m_tags[$];
    bit   m_err;
    bit   e_acc;
    logic [3:0] e_next;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h, t=%0t", name, act, exp, $time);
    endtask

    task automatic sample();
        int g;
        logic e_req;
        logic [3:0] e_strobe;
        @(negedge fclk);
        e_acc  = 0;
        e_next = '0;
        if (m_valid) begin
            g        = m_grant;
            e_req    = m_own && ch_req[g] && !(ch_rnw[g] && m_tags.size() == TD);
            e_acc    = e_req && dma_next;
            e_next   = e_acc ? 4'(1 << g) : 4'd0;
            e_strobe = (dma_strobe && m_tags.size() > 0) ? 4'(1 << m_tags[0]) : 4'd0;
            chk("dma_req", dma_req, e_req);
            chk("ch_next", ch_next, e_next);
            chk("ch_strobe", ch_strobe, e_strobe);
            chk("busy", busy, m_own || m_tags.size() > 0);
            chk("err", err, m_err);
            chk("ch_rddata", ch_rddata, dma_rddata);
            if (m_own) begin
                chk("dma_rnw", dma_rnw, ch_rnw[g]);
                chk("dma_addr", dma_addr, ch_addr[21*g +: 21]);
                chk("dma_wrdata", dma_wrdata, ch_wrdata[16*g +: 16]);
                chk("dma_bsel", dma_bsel, ch_bsel[2*g +: 2]);
            end
        end
    endtask

    task automatic advance();
        if (!rst_n) begin
            m_valid = 1;
            m_own   = 0;
            m_grant = 0;
            m_last  = C - 1;
            m_bcnt  = 0;
            m_err   = 0;
            m_tags.delete();
        end else if (m_valid) begin
            if (dma_strobe) begin
                if (m_tags.size() > 0) void'(m_tags.pop_front());
                else m_err = 1;
            end
            if (e_acc && ch_rnw[m_grant]) m_tags.push_back(m_grant);
            if (m_own) begin
                if (e_acc) begin
                    m_bcnt++;
                    if (m_bcnt == B) begin m_own = 0; m_last = m_grant; end
                end else if (!ch_req[m_grant]) begin
                    m_own = 0; m_last = m_grant;
                end
            end else begin
                for (int k = 1; k <= C; k++) begin
                    if (ch_req[(m_last + k) % C]) begin
                        m_own = 1; m_grant = (m_last + k) % C; m_bcnt = 0;
                        break;
                    end
                end
            end
        end
        @(posedge fclk);
        #1;
    endtask

    task automatic clr();
        ch_req = '0; ch_rnw = '0; ch_addr = '0; ch_wrdata = '0; ch_bsel = '0;
        dma_next = 0; dma_strobe = 0; dma_rddata = '0;
    endtask

    task automatic setch(input int i, input logic req, input logic rnw, input logic [20:0] a,
                         input logic [15:0] wd, input logic [1:0] bs);
        ch_req[i] = req;
        ch_rnw[i] = rnw;
        ch_addr[21*i +: 21]  = a;
        ch_wrdata[16*i +: 16] = wd;
        ch_bsel[2*i +: 2]    = bs;
    endtask

    task automatic do_reset();
        clr();
        rst_n = 0;
        sample(); advance();
        sample();
        chk("rst_dma_req", dma_req, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", err, 0);
        chk("rst_ch_next", ch_next, 0);
        chk("rst_ch_strobe", ch_strobe, 0);
        advance();
        rst_n = 1;
    endtask

    logic [3:0] log_next [32];
    int n0, n1;

    initial begin
        rst_n = 0;
        clr();

        // Single read on channel 2
        do_reset();
        for (int c = 0; c < 8; c++) begin
            if (c == 0) setch(2, 1, 1, 21'h01234, 16'h0, 2'b11);
            if (c == 2) dma_next = 1;
            if (c == 3) begin dma_next = 0; ch_req[2] = 0; end
            if (c == 5) begin dma_strobe = 1; dma_rddata = 16'hBEEF; end
            if (c == 6) dma_strobe = 0;
            sample();
            if (c == 0) chk("t1_req_c0", dma_req, 0);
            if (c == 1) begin
                chk("t1_req_c1", dma_req, 1);
                chk("t1_addr_c1", dma_addr, 21'h01234);
                chk("t1_next_c1", ch_next, 4'b0000);
            end
            if (c == 2) chk("t1_next_c2", ch_next, 4'b0100);
            if (c == 5) begin
                chk("t1_strobe_c5", ch_strobe, 4'b0100);
                chk("t1_rddata_c5", ch_rddata, 16'hBEEF);
            end
            if (c == 6) chk("t1_busy_c6", busy, 0);
            advance();
        end

        // Two continuous writers, burst rotation
        do_reset();
        setch(0, 1, 0, 21'h00100, 16'h1111, 2'b11);
        setch(1, 1, 0, 21'h00200, 16'h2222, 2'b01);
        dma_next = 1;
        for (int c = 0; c < 21; c++) begin
            sample();
            log_next[c] = ch_next;
            advance();
        end
        n0 = 0; n1 = 0;
        for (int c = 1; c <= 8; c++) if (log_next[c] == 4'b0001) n0++;
        for (int c = 10; c <= 17; c++) if (log_next[c] == 4'b0010) n1++;
        chk("t2_ch0_pulses", n0, 8);
        chk("t2_dead_c9", log_next[9], 0);
        chk("t2_ch1_pulses", n1, 8);
        chk("t2_dead_c18", log_next[18], 0);
        chk("t2_ch0_again", log_next[19], 4'b0001);

        // Tag FIFO fills on channel 3 reads
        do_reset();
        setch(3, 1, 1, 21'h1F000, 16'h0, 2'b11);
        dma_next = 1;
        for (int c = 0; c < 9; c++) begin
            if (c == 6) begin dma_strobe = 1; dma_rddata = 16'h1234; end
            if (c == 7) dma_strobe = 0;
            sample();
            if (c == 4) chk("t3_next_c4", ch_next, 4'b1000);
            if (c == 5) chk("t3_req_full", dma_req, 0);
            if (c == 6) begin
                chk("t3_strobe", ch_strobe, 4'b1000);
                chk("t3_req_c6", dma_req, 0);
            end
            if (c == 7) chk("t3_req_again", dma_req, 1);
            advance();
        end

        // In-order strobes and sticky err
        do_reset();
        for (int c = 0; c < 13; c++) begin
            if (c == 0) begin
                setch(0, 1, 1, 21'h0AAAA, 16'h0, 2'b11);
                setch(1, 1, 1, 21'h0BBBB, 16'h0, 2'b11);
                dma_next = 1;
            end
            if (c == 2) ch_req[0] = 0;
            if (c == 5) begin ch_req[1] = 0; dma_next = 0; end
            if (c == 6) begin dma_strobe = 1; dma_rddata = 16'hAAAA; end
            if (c == 7) dma_rddata = 16'hBBBB;
            if (c == 8) dma_rddata = 16'hCCCC;
            if (c == 9) dma_strobe = 0;
            sample();
            if (c == 1) chk("t4_next_ch0", ch_next, 4'b0001);
            if (c == 4) chk("t4_next_ch1", ch_next, 4'b0010);
            if (c == 6) chk("t4_strobe_ch0", ch_strobe, 4'b0001);
            if (c == 7) chk("t4_strobe_ch1", ch_strobe, 4'b0010);
            if (c == 8) begin
                chk("t4_strobe_empty", ch_strobe, 4'b0000);
                chk("t4_err_before", err, 0);
            end
            if (c == 9)  chk("t4_err_set", err, 1);
            if (c == 12) chk("t4_err_sticky", err, 1);
            advance();
        end

        // Channel 1 releases early, channel 2 takes over
        do_reset();
        for (int c = 0; c < 8; c++) begin
            if (c == 0) begin
                setch(1, 1, 0, 21'h01111, 16'h5555, 2'b10);
                setch(2, 1, 0, 21'h02222, 16'h6666, 2'b01);
                dma_next = 1;
            end
            if (c == 4) begin ch_req[1] = 0; dma_next = 0; end
            sample();
            if (c >= 1 && c <= 3) chk("t5_next_ch1", ch_next, 4'b0010);
            if (c == 4) chk("t5_req_c4", dma_req, 0);
            if (c == 5) chk("t5_req_idle", dma_req, 0);
            if (c == 6) begin
                chk("t5_req_ch2", dma_req, 1);
                chk("t5_addr_ch2", dma_addr, 21'h02222);
            end
            advance();
        end

        // Reset mid-burst with two tags outstanding
        do_reset();
        for (int c = 0; c < 7; c++) begin
            if (c == 0) begin setch(0, 1, 1, 21'h00ABC, 16'h0, 2'b11); dma_next = 1; end
            if (c == 3) begin dma_next = 0; rst_n = 0; end
            if (c == 4) begin rst_n = 1; setch(3, 1, 0, 21'h1DDDD, 16'h7777, 2'b11); end
            sample();
            if (c == 3) chk("t6_busy_pre", busy, 1);
            if (c == 4) begin
                chk("t6_req_post", dma_req, 0);
                chk("t6_busy_post", busy, 0);
            end
            if (c == 5) begin
                chk("t6_req_ch0", dma_req, 1);
                chk("t6_addr_ch0", dma_addr, 21'h00ABC);
            end
            advance();
        end

        // Randomized traffic
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            rst_n = ($urandom_range(499) != 0);
            for (int i = 0; i < C; i++) begin
                if (!ch_req[i]) begin
                    if ($urandom_range(3) == 0)
                        setch(i, 1, 1'($urandom), 21'($urandom), 16'($urandom), 2'($urandom));
                end else if (e_next[i]) begin
                    if ($urandom_range(3) == 0) ch_req[i] = 0;
                    else setch(i, 1, 1'($urandom), 21'($urandom), 16'($urandom), 2'($urandom));
                end
            end
            dma_next   = ($urandom_range(3) != 0);
            dma_strobe = (m_tags.size() > 0) && ($urandom_range(1) == 0);
            dma_rddata = 16'($urandom);
            sample();
            advance();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
